spram_bank_ctrl: RTL

Parametrised, byte-addressable RAM built from UP5K SB_SPRAM256KA primitives.
Width and bank count are configurable.
Each bank has idle-timeout power management: it drops into SPRAM SLEEP after inactivity and wakes automatically on access, with a ready/valid handshake towards the bus master.
Sits on the soft-CPU/DMA bus as main RAM.

---
 rtl/spram_bank_ctrl_if.sv | 17 +
 rtl/spram_bank_ctrl.sv | 109 ++++++++++
 2 files changed

// File: rtl/spram_bank_ctrl_if.sv
// spram_bank_ctrl_if: master/slave bus between a soft-CPU/DMA master and spram_bank_ctrl.
interface spram_bank_ctrl_if #(
    parameter int WIDTH     = 32,
    parameter int NUM_BANKS = 2
);
    localparam int ADDR_W = 14 + $clog2(WIDTH / 8) + $clog2(NUM_BANKS);
    logic                 sel;
    logic [WIDTH/8-1:0]   we;
    logic [ADDR_W-1:0]    addr;
    logic [WIDTH-1:0]     wdat;
    logic [WIDTH-1:0]     rdat;
    logic                 rdy;
    logic                 rvalid;
    logic [NUM_BANKS-1:0] bank_awake;
    modport master (output sel, we, addr, wdat, input rdat, rdy, rvalid, bank_awake);
    modport slave  (input sel, we, addr, wdat, output rdat, rdy, rvalid, bank_awake);
endinterface

// File: rtl/spram_bank_ctrl.sv
// spram_bank_ctrl: banked byte-addressable SPRAM main memory with per-bank idle sleep and auto-wake.
// Each bank array is written so it maps onto WIDTH/16 SB_SPRAM256KA side by side (byte enables -> MASKWREN pairs).
module spram_bank_ctrl #(
    parameter int WIDTH        = 32,
    parameter int NUM_BANKS    = 2,
    parameter int IDLE_TIMEOUT = 1024,
    parameter int WAKE_CYCLES  = 3
) (
    input logic            clk,
    input logic            rst,
    spram_bank_ctrl_if.slave bus
);
    localparam int LB = $clog2(WIDTH / 8);
    localparam int BW = NUM_BANKS > 1 ? $clog2(NUM_BANKS) : 1;
    localparam int IW = IDLE_TIMEOUT > 1 ? $clog2(IDLE_TIMEOUT) : 1;
    localparam int WW = $clog2(WAKE_CYCLES + 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT > 0 ? IDLE_TIMEOUT - 1 : 0);

    if (WIDTH != 16 && WIDTH != 32) begin : g_bad_width
        $error("spram_bank_ctrl: WIDTH must be 16 or 32");
    end
    if (NUM_BANKS != 1 && NUM_BANKS != 2 && NUM_BANKS != 4) begin : g_bad_banks
        $error("spram_bank_ctrl: NUM_BANKS must be 1, 2 or 4");
    end
    if (NUM_BANKS * WIDTH / 16 > 4) begin : g_too_many
        $error("spram_bank_ctrl: design needs more than the 4 available SPRAMs");
    end
    if (WAKE_CYCLES < 1) begin : g_bad_wake
        $error("spram_bank_ctrl: WAKE_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {AWAKE, SLEEP, WAKING} state_t;

    state_t                          st   [NUM_BANKS];
    logic [IW-1:0]                   idle [NUM_BANKS];
    logic [WW-1:0]                   wake [NUM_BANKS];
    logic [NUM_BANKS-1:0][WIDTH-1:0] q;
    logic [NUM_BANKS-1:0]            cs;
    logic [NUM_BANKS-1:0]            awake;
    logic [13:0]                     word;
    logic [BW-1:0]                   bank;
    logic [BW-1:0]                   rbank;
    logic                            acc;
    logic                            rvalid;

    assign word           = 14'(bus.addr >> LB);
    assign bank           = BW'(bus.addr >> (14 + LB));
    assign bus.rdy        = st[bank] == AWAKE;
    assign acc            = bus.sel & bus.rdy;
    assign bus.rvalid     = rvalid;
    assign bus.rdat       = rvalid ? q[rbank] : '0;
    assign bus.bank_awake = awake;

    always_comb begin
        cs    = '0;
        awake = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            cs[i]    = acc && bank == BW'(i);
            awake[i] = st[i] == AWAKE;
        end
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            for (int i = 0; i < NUM_BANKS; i++) begin
                st[i]   <= AWAKE;
                idle[i] <= '0;
                wake[i] <= '0;
            end
            rvalid <= 1'b0;
            rbank  <= '0;
        end else begin
            for (int i = 0; i < NUM_BANKS; i++)
                case (st[i])
                    AWAKE:
                        if (cs[i]) idle[i] <= '0;
                        else if (IDLE_TIMEOUT != 0 && idle[i] == IDLE_LAST) begin
                            st[i]   <= SLEEP;
                            idle[i] <= '0;
                        end else if (IDLE_TIMEOUT != 0) idle[i] <= idle[i] + 1'b1;
                    SLEEP:
                        if (bus.sel && bank == BW'(i)) begin
                            st[i]   <= WAKING;
                            wake[i] <= WW'(WAKE_CYCLES);
                        end
                    WAKING: begin
                        wake[i] <= wake[i] - 1'b1;
                        if (wake[i] <= WW'(1)) begin
                            st[i]   <= AWAKE;
                            idle[i] <= '0;
                        end
                    end
                    default: st[i] <= AWAKE;
                endcase
            rvalid <= acc && !(|bus.we);
            rbank  <= acc ? bank : rbank;
        end

    // Contents are never reset: the SPRAMs keep data through SLEEP and controller reset.
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [WIDTH-1:0] mem [16384];
        always_ff @(posedge clk)
            if (cs[b]) begin
                for (int i = 0; i < WIDTH / 8; i++)
                    if (bus.we[i]) mem[word][8*i +: 8] <= bus.wdat[8*i +: 8];
                q[b] <= mem[word];
            end
    end
endmodule
